// File: rtl/ahb_wait_slave.sv
// AHB-Lite responder: word-addressed memory, WAIT_STATES wait cycles per beat,
// two-cycle ERROR response for non-word or misaligned transfers.
module ahb_wait_slave #(
  parameter int ADDR_W      = 6,
  parameter int WAIT_STATES = 1
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LAST,
    S_ERR1,
    S_ERR2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt, addr_idx;
  logic              wr_q, wr_nxt;
  logic              accept, bad_xfer;
  logic              rd_load;
  logic [31:0]       rd_nxt;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  // hburst, htrans[0] and the upper address bits play no part in decoding
  logic unused_bits;
  assign unused_bits = ^{hburst, htrans[0], haddr[31:ADDR_W+2]};

  always_comb begin
    addr_idx = haddr[ADDR_W+1:2];
    accept   = hsel && hready && htrans[1];
    bad_xfer = (hsize != 3'b010) || (haddr[1:0] != 2'b00);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    wr_nxt    = wr_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    case (state)
      S_IDLE, S_LAST: begin
        state_nxt = S_IDLE;
        if (accept) begin
          idx_nxt = addr_idx;
          wr_nxt  = hwrite;
          if (bad_xfer) begin
            state_nxt = S_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt = S_LAST;
          end
        end
      end
      S_WAIT: begin
        hreadyout = 1'b0;
        cnt_nxt   = cnt - 4'd1;
        if (cnt == 4'd1) state_nxt = S_LAST;
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_nxt = S_ERR2;
      end
      S_ERR2: begin
        hresp     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // A write retiring in LAST on the same edge a read enters LAST must forward hwdata
  always_comb begin
    rd_load = (state_nxt == S_LAST);
    if (state == S_LAST && wr_q && idx_nxt == idx) rd_nxt = hwdata;
    else                                           rd_nxt = mem[idx_nxt];
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state  <= S_IDLE;
      cnt    <= '0;
      idx    <= '0;
      wr_q   <= 1'b0;
      hrdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      wr_q  <= wr_nxt;
      if (rd_load) hrdata <= rd_nxt;
    end
  end

  always_ff @(posedge hclk) begin
    if (hresetn && state == S_LAST && wr_q) mem[idx] <= hwdata;
  end

endmodule

// File: tb/tb_ahb_wait_slave.sv
// Directed bench for ahb_wait_slave: three instances with W=1, W=0 and W=3
// share one bus; cur selects which one is addressed and drives hready.
module tb_ahb_wait_slave;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel_d;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic        hready;
  logic [2:0]  hsel;
  logic        ro0, ro1, ro2, rs0, rs1, rs2;
  logic [31:0] rd0, rd1, rd2;
  logic        rdy, rsp_s;
  logic [31:0] rdat;
  int unsigned cur;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 hclk = ~hclk;

  always_comb begin
    hsel = '0;
    case (cur)
      0:       begin hsel[0] = hsel_d; rdy = ro0; rsp_s = rs0; rdat = rd0; end
      1:       begin hsel[1] = hsel_d; rdy = ro1; rsp_s = rs1; rdat = rd1; end
      default: begin hsel[2] = hsel_d; rdy = ro2; rsp_s = rs2; rdat = rd2; end
    endcase
  end
  assign hready = rdy;

  ahb_wait_slave #(.ADDR_W(6), .WAIT_STATES(1)) u_w1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[0]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro0), .hresp(rs0), .hrdata(rd0));
  ahb_wait_slave #(.ADDR_W(6), .WAIT_STATES(0)) u_w0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[1]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro1), .hresp(rs1), .hrdata(rd1));
  ahb_wait_slave #(.ADDR_W(6), .WAIT_STATES(3)) u_w3 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[2]), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hwdata(hwdata), .hready(hready),
    .hreadyout(ro2), .hresp(rs2), .hrdata(rd2));

  typedef struct {
    int unsigned dut;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned waits;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    hsel_d = 1'b0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'b010;
    haddr  = '0;
    hburst = 3'b000;
  endtask

  // Called #1 after a rising edge with the target slave idle; returns the same way
  task automatic xfer(input int unsigned d, input logic wr, input logic [31:0] a,
                      input logic [2:0] sz, input logic [31:0] wd,
                      output int unsigned waits, output logic resp_low,
                      output logic resp_last, output logic [31:0] rdv, output logic tmo);
    cur    = d;
    hsel_d = 1'b1;
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    @(posedge hclk); #1;
    idle_bus();
    hwdata    = wd;
    waits     = 0;
    resp_low  = 1'b0;
    resp_last = 1'b0;
    rdv       = '0;
    tmo       = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge hclk);
      if (!rdy) begin
        waits++;
        resp_low = resp_low | rsp_s;
      end else begin
        resp_last = rsp_s;
        rdv       = rdat;
        tmo       = 1'b0;
      end
      @(posedge hclk); #1;
      if (!tmo) break;
    end
  endtask

  initial begin
    int unsigned waits;
    logic        resp_low, resp_last, tmo;
    logic [31:0] rdv;
    logic [31:0] burst_exp [4];
    int unsigned nxt, got, cyc;

    // dut, wr, addr, size, wdata, rdata, waits, err
    vecs.push_back('{0, 1'b1, 32'h04, 3'b010, 32'h0000_0001, 32'h0, 1, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h04, 3'b010, 32'h0,         32'h0000_0001, 1, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h04, 3'b001, 32'h0000_0BAD, 32'h0, 1, 1'b1});
    vecs.push_back('{0, 1'b0, 32'h04, 3'b010, 32'h0,         32'h0000_0001, 1, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h06, 3'b010, 32'h0000_0BAD, 32'h0, 1, 1'b1});
    vecs.push_back('{0, 1'b0, 32'h04, 3'b010, 32'h0,         32'h0000_0001, 1, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h104, 3'b010, 32'h0,        32'h0000_0001, 1, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h08, 3'b010, 32'h3, 32'h0, 1, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h0C, 3'b010, 32'h4, 32'h0, 1, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h10, 3'b010, 32'h5, 32'h0, 1, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h14, 3'b010, 32'h6, 32'h0, 1, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h10, 3'b010, 32'h1234_5678, 32'h0, 0, 1'b0});
    vecs.push_back('{1, 1'b0, 32'h10, 3'b010, 32'h0, 32'h1234_5678, 0, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h12, 3'b010, 32'hFFFF_FFFF, 32'h0, 1, 1'b1});
    vecs.push_back('{1, 1'b0, 32'h10, 3'b010, 32'h0, 32'h1234_5678, 0, 1'b0});
    vecs.push_back('{2, 1'b1, 32'h00, 3'b010, 32'h11, 32'h0, 3, 1'b0});
    vecs.push_back('{2, 1'b0, 32'h00, 3'b010, 32'h0, 32'h11, 3, 1'b0});
    vecs.push_back('{2, 1'b1, 32'h20, 3'b011, 32'h99, 32'h0, 1, 1'b1});
    vecs.push_back('{2, 1'b1, 32'h20, 3'b010, 32'h22, 32'h0, 3, 1'b0});
    vecs.push_back('{2, 1'b0, 32'h20, 3'b010, 32'h0, 32'h22, 3, 1'b0});

    cur     = 0;
    hwdata  = '0;
    idle_bus();
    hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst w1 hreadyout", 32'(ro0), 32'd1);
    chk("rst w1 hresp",     32'(rs0), 32'd0);
    chk("rst w1 hrdata",    rd0,      32'h0);
    chk("rst w0 hreadyout", 32'(ro1), 32'd1);
    chk("rst w0 hresp",     32'(rs1), 32'd0);
    chk("rst w0 hrdata",    rd1,      32'h0);
    chk("rst w3 hreadyout", 32'(ro2), 32'd1);
    chk("rst w3 hresp",     32'(rs2), 32'd0);
    chk("rst w3 hrdata",    rd2,      32'h0);
    hresetn = 1'b1;
    @(posedge hclk); #1;

    foreach (vecs[i]) begin
      xfer(vecs[i].dut, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata,
           waits, resp_low, resp_last, rdv, tmo);
      chk($sformatf("v%0d timeout", i),   32'(tmo),       32'd0);
      chk($sformatf("v%0d waits", i),     32'(waits),     32'(vecs[i].waits));
      chk($sformatf("v%0d resp_wait", i), 32'(resp_low),  32'(vecs[i].err));
      chk($sformatf("v%0d resp_last", i), 32'(resp_last), 32'(vecs[i].err));
      if (!vecs[i].wr && !vecs[i].err)
        chk($sformatf("v%0d rdata", i), rdv, vecs[i].rdata);
    end

    // INCR4 read burst on the W=1 slave, pipelined address phases
    burst_exp = '{32'h3, 32'h4, 32'h5, 32'h6};
    cur    = 0;
    hsel_d = 1'b1;
    htrans = 2'b10;
    haddr  = 32'h08;
    hwrite = 1'b0;
    hsize  = 3'b010;
    hburst = 3'b011;
    @(posedge hclk); #1;
    nxt = 1; got = 0; cyc = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      if (nxt < 4) begin
        htrans = 2'b11;
        haddr  = 32'(8 + 4 * nxt);
      end else begin
        idle_bus();
      end
      @(negedge hclk);
      cyc++;
      if (rdy) begin
        chk($sformatf("burst beat%0d rdata", got), rdat, burst_exp[got]);
        got++;
        nxt++;
      end
      @(posedge hclk); #1;
    end
    idle_bus();
    chk("burst beats", 32'(got), 32'd4);
    chk("burst cycles", 32'(cyc), 32'd8);

    // W=0 write immediately followed by a read of the same word
    cur    = 1;
    hsel_d = 1'b1;
    htrans = 2'b10;
    haddr  = 32'h10;
    hwrite = 1'b1;
    hsize  = 3'b010;
    @(posedge hclk); #1;
    hwdata = 32'hDEAD_BEEF;
    hwrite = 1'b0;
    @(negedge hclk);
    chk("bypass write ready", 32'(rdy), 32'd1);
    @(posedge hclk); #1;
    idle_bus();
    @(negedge hclk);
    chk("bypass read ready", 32'(rdy), 32'd1);
    chk("bypass read resp",  32'(rsp_s), 32'd0);
    chk("bypass read data",  rdat, 32'hDEAD_BEEF);
    @(posedge hclk); #1;
    xfer(1, 1'b0, 32'h10, 3'b010, 32'h0, waits, resp_low, resp_last, rdv, tmo);
    chk("bypass reread timeout", 32'(tmo), 32'd0);
    chk("bypass reread data", rdv, 32'hDEAD_BEEF);

    // W=3 write aborted by reset in its second wait cycle
    cur    = 2;
    hsel_d = 1'b1;
    htrans = 2'b10;
    haddr  = 32'h00;
    hwrite = 1'b1;
    hsize  = 3'b010;
    @(posedge hclk); #1;
    idle_bus();
    hwdata = 32'h55;
    @(negedge hclk);
    chk("rstwait wait1 ready", 32'(rdy), 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b0;
    @(negedge hclk);
    chk("rstwait wait2 ready", 32'(rdy), 32'd0);
    @(posedge hclk); #1;
    hresetn = 1'b1;
    @(negedge hclk);
    chk("rstwait after ready", 32'(rdy), 32'd1);
    chk("rstwait after resp",  32'(rsp_s), 32'd0);
    chk("rstwait after rdata", rdat, 32'h0);
    @(posedge hclk); #1;
    xfer(2, 1'b0, 32'h00, 3'b010, 32'h0, waits, resp_low, resp_last, rdv, tmo);
    chk("rstwait read timeout", 32'(tmo), 32'd0);
    chk("rstwait read waits", 32'(waits), 32'd3);
    chk("rstwait read data", rdv, 32'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
